dmem_responder: RTL and testbench

Data-memory responder that services load/store requests from the CPU datapath's data-memory port.
- Owns a byte-addressable word array.
- Adds a configurable number of wait states.
- Performs byte/half/word lane steering with sign or zero extension.
- Reports misaligned or illegal accesses.
- Uses a valid/ready handshake on both request and response channels so the datapath can later be stalled on memory.

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressable word array with configurable wait states,
// byte/half/word lane steering, sign/zero extension and misalignment reporting.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error,
   output logic [1:0]            dbg_state
);

   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
   localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt;
   logic            do_access, err_resp, accept, req_err;

   logic                  lat_write, lat_unsigned;
   logic [1:0]            lat_size;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [31:0]           lat_wdata;

   logic                  acc_write, acc_unsigned;
   logic [1:0]            acc_size;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [31:0]           acc_wdata;
   logic [ADDR_WIDTH-3:0] word_idx;
   logic [1:0]            lane;

   logic [31:0] mem [WORDS];
   logic [31:0] rd_word, load_val, wlanes;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [3:0]  be;

   // Both channels: a transfer happens on a rising edge where valid and ready are both 1.
   // req_ready is high only in IDLE; resp_valid is high only in RESP, with data held until resp_ready.
   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign dbg_state  = state;
   assign accept     = req_ready && req_valid;

   assign req_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // With zero wait states the access happens on the acceptance edge, straight from the ports.
   assign acc_write    = (state == ST_IDLE) ? req_write    : lat_write;
   assign acc_size     = (state == ST_IDLE) ? req_size     : lat_size;
   assign acc_unsigned = (state == ST_IDLE) ? req_unsigned : lat_unsigned;
   assign acc_addr     = (state == ST_IDLE) ? req_addr     : lat_addr;
   assign acc_wdata    = (state == ST_IDLE) ? req_wdata    : lat_wdata;
   assign word_idx     = acc_addr[ADDR_WIDTH-1:2];
   assign lane         = acc_addr[1:0];

   assign rd_word = mem[word_idx];
   assign rd_byte = rd_word[{lane, 3'b000} +: 8];
   assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_val = 32'h0;
      case (acc_size)
         2'b00:   load_val = acc_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         2'b01:   load_val = acc_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
         default: load_val = rd_word;
      endcase
   end

   always_comb begin
      be     = 4'b0000;
      wlanes = acc_wdata;
      case (acc_size)
         2'b00: begin
            be     = 4'b0001 << lane;
            wlanes = {4{acc_wdata[7:0]}};
         end
         2'b01: begin
            be     = lane[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{acc_wdata[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   always_comb begin
      state_next = state;
      do_access  = 1'b0;
      err_resp   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_err) begin
                  err_resp   = 1'b1;
                  state_next = ST_RESP;
               end else if (WAIT_CYCLES > 0) begin
                  state_next = ST_WAIT;
               end else begin
                  do_access  = 1'b1;
                  state_next = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               do_access  = 1'b1;
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         resp_rdata <= 32'h0;
         resp_error <= 1'b0;
      end else begin
         state <= state_next;
         if (accept && !req_err) begin
            cnt <= CNT_INIT;
         end else if (state == ST_WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (err_resp) begin
            resp_error <= 1'b1;
            resp_rdata <= 32'h0;
         end else if (do_access) begin
            resp_error <= 1'b0;
            resp_rdata <= acc_write ? 32'h0 : load_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_write    <= req_write;
         lat_size     <= req_size;
         lat_unsigned <= req_unsigned;
         lat_addr     <= req_addr;
         lat_wdata    <= req_wdata;
      end
   end

   // Array has no reset; a commit edge that coincides with reset is suppressed.
   always_ff @(posedge clk) begin
      if (!reset && do_access && acc_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (2 and 0 wait states) checked
// against a byte-array reference model, with directed cases and randomized traffic.
module tb_dmem_responder;
   localparam int AW = 8;

   logic clk;
   logic [1:0]         rst, req_valid, req_write, req_unsigned, resp_ready;
   logic [1:0][1:0]    req_size;
   logic [1:0][AW-1:0] req_addr;
   logic [1:0][31:0]   req_wdata;
   wire  [1:0]         req_ready, resp_valid, resp_error;
   wire  [1:0][31:0]   resp_rdata;
   wire  [1:0][1:0]    dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int wc[2]    = '{2, 0};
   logic [7:0]  mm [2][256];
   logic [32:0] exp_q[$];
   logic [31:0] g;
   logic        ge;

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
      .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]),
      .dbg_state(dbg_state[0])
   );

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
      .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]),
      .dbg_state(dbg_state[1])
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference: memory is a flat byte array; an access touches 2^size consecutive bytes.
   function automatic logic [32:0] model_access(input int d, input logic wr, input logic [1:0] sz,
                                                 input logic uns, input logic [7:0] a,
                                                 input logic [31:0] wd);
      int nb;
      logic [31:0] v;
      nb = 1 << sz;
      if (sz == 2'd3 || (int'(a) % nb) != 0) return {1'b1, 32'h0};
      if (wr) begin
         for (int i = 0; i < nb; i++) mm[d][int'(a) + i] = wd[8*i +: 8];
         return 33'h0;
      end
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mm[d][int'(a) + i]) << (8 * i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      return {1'b0, v};
   endfunction

   task automatic check_idle(input int d, input string tag);
      check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
      check({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
      check({tag, "_rdata"}, resp_rdata[d], 32'h0);
      check({tag, "_error"}, 32'(resp_error[d]), 32'd0);
   endtask

   task automatic drive_req(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [7:0] a, input logic [31:0] wd);
      req_valid[d]    = 1'b1;
      req_write[d]    = wr;
      req_size[d]     = sz;
      req_unsigned[d] = uns;
      req_addr[d]     = a;
      req_wdata[d]    = wd;
   endtask

   // One transaction: issue, measure latency, compare, optionally stall the response
   // (with a competing request held on the request port), then complete it.
   task automatic do_txn(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [7:0] a, input logic [31:0] wd, input int hold,
                         input bit intrude, output logic [31:0] got, output logic got_err);
      logic [32:0] e;
      int cyc, lat;
      e = model_access(d, wr, sz, uns, a, wd);
      exp_q.push_back(e);
      lat = e[32] ? 1 : 1 + wc[d];
      check("req_ready_idle", 32'(req_ready[d]), 32'd1);
      drive_req(d, wr, sz, uns, a, wd);
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      cyc = 1;
      while (!resp_valid[d] && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", 32'(cyc), 32'(lat));
      e       = exp_q.pop_front();
      got     = resp_rdata[d];
      got_err = resp_error[d];
      check("rdata", got, e[31:0]);
      check("error", 32'(got_err), 32'(e[32]));
      for (int i = 0; i < hold; i++) begin
         if (intrude) drive_req(d, 1'b1, 2'd2, 1'b0, {a[7:2], 2'b00}, 32'hBAD0_BAD0);
         @(posedge clk); #1;
         check("hold_valid", 32'(resp_valid[d]), 32'd1);
         check("hold_rdata", resp_rdata[d], e[31:0]);
         check("hold_error", 32'(resp_error[d]), 32'(e[32]));
         check("hold_req_ready", 32'(req_ready[d]), 32'd0);
      end
      resp_ready[d] = 1'b1;
      @(posedge clk); #1;
      resp_ready[d] = 1'b0;
      req_valid[d]  = 1'b0;
      check("done_valid", 32'(resp_valid[d]), 32'd0);
      check("done_req_ready", 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      rst = 2'b11; req_valid = '0; req_write = '0; req_unsigned = '0; resp_ready = '0;
      req_size = '0; req_addr = '0; req_wdata = '0;
      for (int d = 0; d < 2; d++) for (int i = 0; i < 256; i++) mm[d][i] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 2'b00;
      check_idle(0, "rst0");
      check_idle(1, "rst1");

      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 16; w++) do_txn(d, 1'b1, 2'd2, 1'b0, 8'(w * 4), 32'h0, 0, 1'b0, g, ge);

      // Directed, two wait states
      do_txn(0, 1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF, 0, 1'b0, g, ge);
      check("sw_rdata_zero", g, 32'h0);
      do_txn(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 0, 1'b0, g, ge);
      check("lw_10", g, 32'hDEAD_BEEF);
      do_txn(0, 1'b0, 2'd0, 1'b0, 8'h11, 32'h0, 0, 1'b0, g, ge);
      check("lb_11_s", g, 32'hFFFF_FFBE);
      do_txn(0, 1'b0, 2'd0, 1'b1, 8'h11, 32'h0, 0, 1'b0, g, ge);
      check("lb_11_u", g, 32'h0000_00BE);
      do_txn(0, 1'b0, 2'd1, 1'b0, 8'h12, 32'h0, 0, 1'b0, g, ge);
      check("lh_12_s", g, 32'hFFFF_DEAD);
      do_txn(0, 1'b0, 2'd1, 1'b1, 8'h12, 32'h0, 0, 1'b0, g, ge);
      check("lh_12_u", g, 32'h0000_DEAD);
      do_txn(0, 1'b1, 2'd0, 1'b0, 8'h13, 32'h0000_0012, 0, 1'b0, g, ge);
      do_txn(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 0, 1'b0, g, ge);
      check("lw_after_sb", g, 32'h12AD_BEEF);
      do_txn(0, 1'b0, 2'd1, 1'b0, 8'h11, 32'h0, 0, 1'b0, g, ge);
      check("lh_mis_err", 32'(ge), 32'd1);
      check("lh_mis_rdata", g, 32'h0);
      do_txn(0, 1'b1, 2'd2, 1'b0, 8'h12, 32'hFFFF_FFFF, 0, 1'b0, g, ge);
      check("sw_mis_err", 32'(ge), 32'd1);
      do_txn(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 0, 1'b0, g, ge);
      check("lw_after_sw_mis", g, 32'h12AD_BEEF);
      do_txn(0, 1'b0, 2'd3, 1'b0, 8'h10, 32'h0, 0, 1'b0, g, ge);
      check("size11_err", 32'(ge), 32'd1);

      // Backpressure with a competing store presented the whole time
      do_txn(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 5, 1'b1, g, ge);
      check("bp_rdata", g, 32'h12AD_BEEF);
      do_txn(0, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 0, 1'b0, g, ge);
      check("bp_no_accept", g, 32'h12AD_BEEF);

      // Reset while the store sits in WAIT
      do_txn(0, 1'b1, 2'd2, 1'b0, 8'h20, 32'hCAFE_F00D, 0, 1'b0, g, ge);
      do_txn(0, 1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 0, 1'b0, g, ge);
      drive_req(0, 1'b1, 2'd2, 1'b0, 8'h20, 32'h0000_0055);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      check_idle(0, "rst_wait");
      do_txn(0, 1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 0, 1'b0, g, ge);
      check("lw_after_rst_wait", g, 32'hCAFE_F00D);

      // Reset on the commit edge itself
      drive_req(0, 1'b1, 2'd2, 1'b0, 8'h20, 32'h0000_0055);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      check_idle(0, "rst_commit");
      do_txn(0, 1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 0, 1'b0, g, ge);
      check("lw_after_rst_commit", g, 32'hCAFE_F00D);

      // Directed, zero wait states
      do_txn(1, 1'b1, 2'd2, 1'b0, 8'h20, 32'h1122_3344, 0, 1'b0, g, ge);
      do_txn(1, 1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 0, 1'b0, g, ge);
      check("w0_lw_20", g, 32'h1122_3344);
      do_txn(1, 1'b0, 2'd0, 1'b0, 8'h23, 32'h0, 0, 1'b0, g, ge);
      check("w0_lb_23", g, 32'h0000_0011);
      do_txn(1, 1'b0, 2'd1, 1'b0, 8'h21, 32'h0, 2, 1'b1, g, ge);
      check("w0_lh_mis_err", 32'(ge), 32'd1);
      drive_req(1, 1'b1, 2'd2, 1'b0, 8'h20, 32'h0000_0055);
      rst[1] = 1'b1;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      req_valid[1] = 1'b0;
      check_idle(1, "w0_rst");
      do_txn(1, 1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 0, 1'b0, g, ge);
      check("w0_lw_after_rst", g, 32'h1122_3344);

      // Randomized traffic against the model
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 60; n++) begin
            do_txn(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), g, ge);
         end
         for (int w = 0; w < 16; w++) do_txn(d, 1'b0, 2'd2, 1'b0, 8'(w * 4), 32'h0, 0, 1'b0, g, ge);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
